cpu_int_arbiter: RTL

- Interrupt scheduler in front of the PDP2011 CPU core.
- Arbitrates between NDEV Unibus-style device bus requests (BR4..BR7) and the programmed-interrupt request from the PIRQ register (pir_in[7:5]).
- Compares the winner against the current PSW priority, presents a single request plus vector to the CPU, and completes the grant/acknowledge handshake back to the winning device.

---
 rtl/cpu_int_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/cpu_int_arbiter.sv
// cpu_int_arbiter: device BR4-7 + PIRQ interrupt scheduler for the CPU; define INT_ARB_RR_EN for round-robin among equal-level devices
module cpu_int_arbiter #(
  parameter int         NDEV    = 4,
  parameter logic [8:0] PIR_VEC = 9'o240
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NDEV-1:0]   dev_irq,
  input  logic [2*NDEV-1:0] dev_br,
  input  logic [9*NDEV-1:0] dev_vec,
  output logic [NDEV-1:0]   dev_iack,
  input  logic [15:0]       pir_in,
  input  logic [2:0]        psw_pri,
  output logic              cpu_irq,
  output logic [8:0]        cpu_vec,
  output logic [2:0]        cpu_level,
  output logic              cpu_src_pir,
  input  logic              cpu_iack
);
  localparam int IW = NDEV > 1 ? $clog2(NDEV) : 1;
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
  state_t          r_state, w_next;
  logic [IW-1:0]   r_idx, w_dev_win;
  logic [8:0]      r_vec, w_win_vec;
  logic [2:0]      r_level, w_dev_max, w_pir_lvl, w_win_lvl;
  logic            r_src_pir, r_mask;
  logic [2:0]      w_lvl [NDEV];
  logic [8:0]      w_dvec [NDEV];
  logic [NDEV-1:0] w_elig;
  logic            w_any_dev, w_pir_elig, w_win_pir, w_any, w_still, w_latch;
  logic            w_unused;
`ifdef INT_ARB_RR_EN
  logic [IW-1:0]   r_ptr;
`endif
  assign w_unused = ^{pir_in[15:8], pir_in[4:0]};
  for (genvar i = 0; i < NDEV; i++) begin : g_dev
    assign w_lvl[i]  = {1'b1, dev_br[2*i +: 2]};
    assign w_dvec[i] = dev_vec[9*i +: 9] & 9'o774;
    assign w_elig[i] = dev_irq[i] && (w_lvl[i] > psw_pri) && !(r_state == IDLE && r_mask && IW'(i) == r_idx);
  end
  always_comb begin
    w_dev_max = '0;
    for (int i = 0; i < NDEV; i++)
      w_dev_max = (w_elig[i] && w_lvl[i] > w_dev_max) ? w_lvl[i] : w_dev_max;
    w_dev_win = '0;
`ifdef INT_ARB_RR_EN
    for (int k = NDEV - 1; k >= 0; k--)
      w_dev_win = (w_elig[(int'(r_ptr) + k) % NDEV] && w_lvl[(int'(r_ptr) + k) % NDEV] == w_dev_max)
                  ? IW'((int'(r_ptr) + k) % NDEV) : w_dev_win;
`else
    for (int i = NDEV - 1; i >= 0; i--)
      w_dev_win = (w_elig[i] && w_lvl[i] == w_dev_max) ? IW'(i) : w_dev_win;
`endif
  end
  assign w_any_dev  = |w_elig;
  assign w_pir_lvl  = pir_in[7:5];
  assign w_pir_elig = w_pir_lvl > psw_pri;
  assign w_win_pir  = w_pir_elig && (!w_any_dev || w_pir_lvl > w_dev_max);
  assign w_any      = w_any_dev || w_pir_elig;
  assign w_win_lvl  = w_win_pir ? w_pir_lvl : w_dev_max;
  assign w_win_vec  = w_win_pir ? PIR_VEC : w_dvec[w_dev_win];
  assign w_still    = r_src_pir ? (w_pir_lvl >= r_level && r_level > psw_pri)
                                : (dev_irq[r_idx] && r_level > psw_pri);
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      IDLE: begin
        w_latch = w_any;
        w_next  = w_any ? REQ : IDLE;
      end
      REQ: begin
        w_latch = !cpu_iack && w_still && w_any && (w_win_lvl > r_level);
        w_next  = cpu_iack ? ACK : (w_still ? REQ : IDLE);
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_vec     <= '0;
      r_level   <= '0;
      r_src_pir <= 1'b0;
      r_mask    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mask  <= (r_state == ACK) && !r_src_pir;
      if (w_latch) begin
        r_idx     <= w_dev_win;
        r_vec     <= w_win_vec;
        r_level   <= w_win_lvl;
        r_src_pir <= w_win_pir;
      end
    end
  end
`ifdef INT_ARB_RR_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      r_ptr <= '0;
    else if (r_state == ACK && !r_src_pir)
      r_ptr <= (int'(r_idx) == NDEV - 1) ? '0 : r_idx + 1'b1;
  end
`endif
  assign cpu_irq     = r_state == REQ;
  assign cpu_vec     = r_vec;
  assign cpu_level   = r_level;
  assign cpu_src_pir = r_src_pir;
  assign dev_iack    = (r_state == ACK && !r_src_pir) ? (NDEV'(1) << r_idx) : '0;
endmodule
